// File: rtl/plot_scaler_fifo_if.sv
// Cell-write and pixel-write buses of plot_scaler_fifo. The scaler uses the
// slave view (consumes cells, produces pixels); the upstream/adapter side uses master.
interface plot_scaler_fifo_if;
  logic       plot_in;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic       out_ready;
  logic       vga_plot;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;

  modport slave (
    input  plot_in, x_in, y_in, colour_in, out_ready,
    output vga_plot, vga_x, vga_y, vga_colour
  );

  modport master (
    output plot_in, x_in, y_in, colour_in, out_ready,
    input  vga_plot, vga_x, vga_y, vga_colour
  );
endinterface

// File: rtl/plot_scaler_fifo.sv
// Queues 160x120 cell writes and replays each as a 2x2 block on a 320x240 pixel port.
// Optional PLOT_DROP_CNT_EN adds a saturating count of dropped writes (drop_count).
module plot_scaler_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic clk,
  input  logic rst,
  plot_scaler_fifo_if.slave bus,
  input  logic ovf_clr,
  output logic full,
  output logic empty,
  output logic overflow
`ifdef PLOT_DROP_CNT_EN
  ,
  output logic [7:0] drop_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } cell_t;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              state_q, state_d;
  logic [DEPTH_LOG2:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]          sub_q, sub_d;
  logic [7:0]          cx_q, cx_d;
  logic [6:0]          cy_q, cy_d;
  logic [2:0]          ccol_q, ccol_d;
  logic                ovf_q, ovf_d;

  cell_t mem_q [DEPTH];
  cell_t wr_cell, head;

  logic wr_en, drop, pop, emit, accept;

  // Occupancy flags come from registered pointers only, so a same-cycle pop
  // never rescues a write that arrives while full.
  assign full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                 (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign empty = (wptr_q == rptr_q);

  assign wr_en   = bus.plot_in && !full;
  assign drop    = bus.plot_in && full;
  assign wr_cell = '{x: bus.x_in, y: bus.y_in, col: bus.colour_in};
  assign head    = mem_q[rptr_q[DEPTH_LOG2-1:0]];

  assign emit   = (state_q == EMIT);
  assign accept = emit && bus.out_ready;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wr_cell;
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + PTR_ONE;
    if (pop)   rptr_d = rptr_q + PTR_ONE;
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ccol_d  = ccol_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cx_d    = head.x;
          cy_d    = head.y;
          ccol_d  = head.col;
          sub_d   = 2'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (accept) begin
          if (sub_q != 2'd3) begin
            sub_d = sub_q + 2'd1;
          end else if (!empty) begin
            // Chain straight into the next cell so back-to-back blocks have no gap.
            pop    = 1'b1;
            cx_d   = head.x;
            cy_d   = head.y;
            ccol_d = head.col;
            sub_d  = 2'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.vga_plot   = emit;
    bus.vga_x      = '0;
    bus.vga_y      = '0;
    bus.vga_colour = '0;
    if (emit) begin
      bus.vga_x      = {cx_q, sub_q[0]};
      bus.vga_y      = {cy_q, sub_q[1]};
      bus.vga_colour = ccol_q;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  assign overflow = ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      sub_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ccol_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      sub_q   <= sub_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ccol_q  <= ccol_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef PLOT_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // A clear coinciding with a drop restarts the count at that drop.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (ovf_clr)                  drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_plot_scaler_fifo.sv
// Directed bench for plot_scaler_fifo: latency, pixel order, chaining,
// overflow/drop, backpressure stall and asynchronous reset mid-burst.
module tb_plot_scaler_fifo;
  logic clk;
  logic rst;
  logic ovf_clr;
  logic full, empty, overflow;
`ifdef PLOT_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int n_chk;
  int n_err;

  plot_scaler_fifo_if bus();

  plot_scaler_fifo #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ovf_clr  (ovf_clr),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
`ifdef PLOT_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    bus.plot_in   = 1'b1;
    bus.x_in      = x;
    bus.y_in      = y;
    bus.colour_in = c;
  endtask

  int cnt;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    ovf_clr = 1'b0;
    bus.plot_in = 1'b0;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.colour_in = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_plot",  bus.vga_plot, 0);
    chk("rst_x",     bus.vga_x, 0);
    chk("rst_y",     bus.vga_y, 0);
    chk("rst_col",   bus.vga_colour, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_ovf",   overflow, 0);
    tick();
    rst = 1'b1;
    tick();

    // Single write (5,7,3) -> 2x2 block at (10..11, 14..15)
    put(8'd5, 7'd7, 3'd3);
    tick();
    bus.plot_in = 1'b0;
    chk("sw_lat_plot", bus.vga_plot, 0);
    chk("sw_lat_empty", empty, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("sw_plot", bus.vga_plot, 1);
      chk("sw_x",    bus.vga_x, 10 + (i % 2));
      chk("sw_y",    bus.vga_y, 14 + (i / 2));
      chk("sw_col",  bus.vga_colour, 3);
      tick();
    end
    chk("sw_done_plot", bus.vga_plot, 0);
    chk("sw_done_x",    bus.vga_x, 0);
    chk("sw_done_empty", empty, 1);

    // Back-to-back cells, 8 contiguous pixels
    put(8'd0, 7'd0, 3'd1);
    tick();
    put(8'd159, 7'd119, 3'd7);
    tick();
    bus.plot_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("bb_plot", bus.vga_plot, 1);
      if (i == 0) begin
        chk("bb_first_x", bus.vga_x, 0);
        chk("bb_first_col", bus.vga_colour, 1);
      end
      if (i == 4) begin
        chk("bb_b0_x", bus.vga_x, 318);
        chk("bb_b0_y", bus.vga_y, 238);
      end
      if (i == 7) begin
        chk("bb_last_x",   bus.vga_x, 319);
        chk("bb_last_y",   bus.vga_y, 239);
        chk("bb_last_col", bus.vga_colour, 7);
      end
      tick();
    end
    chk("bb_done_plot", bus.vga_plot, 0);

    // Overflow: 20 writes with the adapter stalled -> 17 kept, 3 dropped
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      put(8'(i), 7'(i), 3'(i));
      tick();
    end
    bus.plot_in = 1'b0;
    chk("ovf_full",  full, 1);
    chk("ovf_flag",  overflow, 1);
    chk("ovf_plot",  bus.vga_plot, 1);
    chk("ovf_head_x", bus.vga_x, 0);
`ifdef PLOT_DROP_CNT_EN
    chk("ovf_cnt", drop_count, 3);
`endif
    // Drop and clear together: set wins, count restarts at 1
    put(8'd99, 7'd99, 3'd1);
    ovf_clr = 1'b1;
    tick();
    bus.plot_in = 1'b0;
    ovf_clr = 1'b0;
    chk("ovf_setwins", overflow, 1);
`ifdef PLOT_DROP_CNT_EN
    chk("ovf_cnt_clr_drop", drop_count, 1);
`endif
    bus.out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.vga_plot) cnt++;
      tick();
    end
    chk("ovf_pixels", cnt, 68);
    chk("ovf_drained_empty", empty, 1);
    chk("ovf_drained_full", full, 0);
    chk("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
`ifdef PLOT_DROP_CNT_EN
    chk("ovf_cnt_cleared", drop_count, 0);
`endif

    // Stall at sub=2 for 5 cycles
    put(8'd20, 7'd30, 3'd5);
    tick();
    bus.plot_in = 1'b0;
    tick();
    tick();
    tick();
    chk("st_sub2_x", bus.vga_x, 40);
    chk("st_sub2_y", bus.vga_y, 61);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_plot", bus.vga_plot, 1);
      chk("st_x",    bus.vga_x, 40);
      chk("st_y",    bus.vga_y, 61);
      chk("st_col",  bus.vga_colour, 5);
    end
    bus.out_ready = 1'b1;
    chk("st_resume_x", bus.vga_x, 40);
    tick();
    chk("st_sub3_x", bus.vga_x, 41);
    chk("st_sub3_y", bus.vga_y, 61);
    tick();
    chk("st_done_plot", bus.vga_plot, 0);

    // Reset mid-burst: 3 cells queued, 2 pixels emitted
    put(8'd1, 7'd1, 3'd2);
    tick();
    put(8'd2, 7'd2, 3'd4);
    tick();
    put(8'd3, 7'd3, 3'd6);
    tick();
    bus.plot_in = 1'b0;
    tick();
    chk("mr_pre_plot", bus.vga_plot, 1);
    chk("mr_pre_x",    bus.vga_x, 2);
    chk("mr_pre_y",    bus.vga_y, 3);
    rst = 1'b0;
    #1;
    chk("mr_plot",  bus.vga_plot, 0);
    chk("mr_x",     bus.vga_x, 0);
    chk("mr_y",     bus.vga_y, 0);
    chk("mr_col",   bus.vga_colour, 0);
    chk("mr_empty", empty, 1);
    chk("mr_full",  full, 0);
    tick();
    tick();
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.vga_plot) cnt++;
    end
    chk("mr_no_pixels", cnt, 0);
    chk("mr_idle_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/plot_scaler_fifo.md
# plot_scaler_fifo

Buffers single-cell plot requests from `snakeInterface` (160x120 logical grid) and expands each into a 2x2 pixel block for a 320x240 VGA adapter. It sits directly downstream of `snakeInterface`, consuming its `plot`/`x_out`/`y_out`/`colour_out`, and drives the adapter's write port. A small FIFO absorbs bursts, because each logical write costs four output cycles.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  asynchronous, active-low reset.
- `plot_in`  in  1  write request; one cell per cycle while high.
- `x_in`  in  8  logical x, 0..159.
- `y_in`  in  7  logical y, 0..119.
- `colour_in`  in  3  cell colour.
- `out_ready`  in  1  adapter accepts the current pixel; tied to 1 for the standard adapter.
- `ovf_clr`  in  1  synchronous clear of `overflow`.
- `vga_plot`  out  1  pixel valid.
- `vga_x`  out  9  pixel x = 2*cx + sub[0].
- `vga_y`  out  8  pixel y = 2*cy + sub[1].
- `vga_colour`  out  3  pixel colour.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- `empty`  out  1  FIFO holds 0 entries.
- `overflow`  out  1  sticky; a write was dropped.

## Operation
- **FIFO:** circular buffer, entry {x,y,colour} (18 bits), with DEPTH_LOG2+1-bit write and read pointers. `full`/`empty` are derived from the registered pointers.
- **Write:** on `plot_in && !full`, store the entry and advance the write pointer.
- **Drop:** on `plot_in && full`, discard the entry and set `overflow`. `full` is evaluated before any same-cycle pop, so a write is dropped even if a pop frees a slot that cycle.
- **Overflow priority:** `overflow` sets on a drop and clears on `ovf_clr`; if both happen in the same cycle, the set wins.
- **FSM states:** IDLE and EMIT.
- **IDLE:** if `!empty`, pop the head into cx/cy/ccol, set sub=0, go to EMIT. Otherwise stay in IDLE.
- **EMIT:** `vga_plot`=1 and the pixel outputs are driven combinationally from cx/cy/ccol/sub.
  - An accept is `vga_plot && out_ready`.
  - On accept with sub<3: sub+1.
  - On accept with sub==3: if `!empty`, pop the next entry, reset sub=0 and stay in EMIT (no bubble). Otherwise go to IDLE.
  - Without an accept, all EMIT registers hold.
- **Pixel order:** sub 0..3 emits (2cx,2cy), (2cx+1,2cy), (2cx,2cy+1), (2cx+1,2cy+1).
- **Arithmetic:** `vga_x`={cx,sub[0]} and `vga_y`={cy,sub[1]}. There is no range checking; out-of-range logical inputs pass through, truncated to the widths above.
- **Outputs outside EMIT:** `vga_x`, `vga_y`, `vga_colour` are 0 whenever `vga_plot`=0.
- **Reset (asynchronous, also mid-burst):** pointers=0, state=IDLE, sub=0, cx/cy/ccol=0, `overflow`=0. The in-flight cell and all queued cells are discarded.
  - Reset values: `vga_plot`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0, `full`=0, `empty`=1.

## Timing
- **Latency:** `plot_in` sampled at edge N (written) → popped at edge N+1 → first pixel valid in the cycle after N+1 (2 cycles) → 4th pixel valid after N+4 when `out_ready`=1.
- **Throughput:** 1 cell per 4 cycles sustained. The input burst tolerance is 2^DEPTH_LOG2 cells plus the one cell being emitted.
- **Simultaneous write and pop:** permitted when not full; the occupancy count is unchanged.
- **Wrap-around:** pointers wrap modulo 2^(DEPTH_LOG2+1).
  - `full` = MSBs differ and the low bits are equal.
  - `empty` = pointers equal.
- **Backpressure:** `out_ready` low stalls the current pixel indefinitely; the FIFO continues to accept writes until `full`.

## Configuration
- **`PLOT_DROP_CNT_EN` defined:** adds output `drop_count` (8 bits, reset 0).
  - Increments on every dropped write and saturates at 255.
  - Cleared by `ovf_clr`; if a drop and `ovf_clr` coincide, the result is 1.
- **`PLOT_DROP_CNT_EN` undefined:** port and logic are absent; the behaviour is otherwise identical.

## Test plan
- **Single write:** reset, then one write with `plot_in`=1, x=5, y=7, colour=3.
  - Expect `vga_plot` high for exactly 4 cycles starting 2 cycles after the write.
  - Pixels in order (10,14),(11,14),(10,15),(11,15), all colour 3.
  - `empty`=1 afterward.
- **Back-to-back cells:** two consecutive writes (0,0,c=1) then (159,119,c=7).
  - Expect 8 contiguous `vga_plot` cycles with no bubble.
  - Last pixel (319,239) colour 7.
- **Overflow:** with `out_ready`=0, write 20 cells. Let D = cells accepted = 16 FIFO entries + 1 popped into the emitter = 17.
  - Expect `full`=1, `overflow`=1 and 3 drops; `drop_count`=3 when `PLOT_DROP_CNT_EN` is defined.
  - Raise `out_ready`: exactly 17*4=68 pixels emitted.
  - Pulse `ovf_clr` → `overflow`=0.
- **Stall:** drop `out_ready` at pixel sub=2 for 5 cycles.
  - Expect `vga_x`/`vga_y`/`vga_colour` stable and `vga_plot`=1 throughout.
  - Resumes with sub=2, then sub=3.
- **Reset mid-burst:** assert `rst` low after 3 queued cells with 2 pixels emitted.
  - Outputs go to 0 and `empty`=1 immediately.
  - No pixels are emitted after release until a new write.
